// File: rtl/uart_tx_fifo_if.sv
// Byte-producer / uart_if-facing signal bundle for uart_tx_fifo.
// The slave modport belongs to the FIFO. The master modport belongs to the producers and the line side.
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  flush_i;
    logic                  clr_ovf_i;
    logic                  full_o;
    logic                  empty_o;
    logic [ADDR_WIDTH:0]   level_o;
    logic                  ovf_o;
    logic                  tx_irq_o;
    logic [DATA_WIDTH-1:0] tx_data_o;
    logic                  tx_busy_i;

    modport slave (
        input  wr_en_i, wr_data_i, flush_i, clr_ovf_i, tx_busy_i,
        output full_o, empty_o, level_o, ovf_o, tx_irq_o, tx_data_o
    );

    modport master (
        output wr_en_i, wr_data_i, flush_i, clr_ovf_i, tx_busy_i,
        input  full_o, empty_o, level_o, ovf_o, tx_irq_o, tx_data_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that launches one tx_irq pulse per byte into uart_if, but only while uart_if is not busy.
// After each launch, a hold window masks tx_busy_i until uart_if has had time to raise it.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int GAP_CLK    = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;
    localparam int CNT_W = (GAP_CLK > 1) ? $clog2(GAP_CLK) : 1;

    typedef enum logic [0:0] {S_IDLE, S_HOLD} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q;
    logic                  ovf_q;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  irq_q, irq_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  full, empty, pop, wr_ok, ovf_set;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    // A pop frees a slot on the same edge, so a full FIFO can still take a byte when it launches one.
    assign wr_ok   = bus.wr_en_i & (~full | pop) & ~bus.flush_i;
    assign ovf_set = bus.wr_en_i & full & ~pop & ~bus.flush_i;

    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        irq_d   = 1'b0;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && !bus.tx_busy_i && !bus.flush_i) begin
                    pop     = 1'b1;
                    irq_d   = 1'b1;
                    data_d  = mem[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // tx_busy_i is not looked at here; uart_if needs a couple of cycles to raise it.
                if (cnt_q == CNT_W'(GAP_CLK - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (bus.flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
                if (pop)   rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
                if (wr_ok && !pop)      level_q <= level_q + LW'(1);
                else if (!wr_ok && pop) level_q <= level_q - LW'(1);
            end
            if (ovf_set)            ovf_q <= 1'b1;
            else if (bus.clr_ovf_i) ovf_q <= 1'b0;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and the level counter define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wr_ptr_q] <= bus.wr_data_i;
    end

    assign bus.full_o    = full;
    assign bus.empty_o   = empty;
    assign bus.level_o   = level_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.tx_irq_o  = irq_q;
    assign bus.tx_data_o = data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo. Each scenario task drives its own stimulus.
// Each task also compares DUT outputs against values worked out by hand.
module tb_uart_tx_fifo;
    logic clk_i = 1'b0;
    logic rst_i;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    logic [7:0] got_data [$];
    int         got_time [$];

    uart_tx_fifo_if bus ();

    uart_tx_fifo dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic collect(input int cycles);
        got_data.delete();
        got_time.delete();
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.tx_irq_o === 1'b1) begin
                got_data.push_back(bus.tx_data_o);
                got_time.push_back(cyc);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tests_run++;
        if (bus.level_o !== 5'd0 || bus.empty_o !== 1'b1 || bus.full_o !== 1'b0 ||
            bus.ovf_o !== 1'b0 || bus.tx_irq_o !== 1'b0 || bus.tx_data_o !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: level=%0d empty=%b full=%b ovf=%b irq=%b data=%h, want 0 1 0 0 0 00",
                     bus.level_o, bus.empty_o, bus.full_o, bus.ovf_o, bus.tx_irq_o, bus.tx_data_o);
        end
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = 8'h41;
        tick();
        bus.wr_en_i = 1'b0;
        tests_run++;
        if (bus.tx_irq_o !== 1'b0 || bus.level_o !== 5'd1 || bus.empty_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_write: irq=%b level=%0d empty=%b, want 0 1 0",
                     bus.tx_irq_o, bus.level_o, bus.empty_o);
        end
        tick();
        tests_run++;
        if (bus.tx_irq_o !== 1'b1 || bus.tx_data_o !== 8'h41 || bus.level_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL first_launch: irq=%b data=%h level=%0d, want 1 41 0",
                     bus.tx_irq_o, bus.tx_data_o, bus.level_o);
        end
        tick();
        tests_run++;
        if (bus.tx_irq_o !== 1'b0 || bus.empty_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_one_cycle: irq=%b empty=%b, want 0 1", bus.tx_irq_o, bus.empty_o);
        end
        repeat (4) tick();
    endtask

    task automatic test_burst();
        bit full_seen = 1'b0;
        got_data.delete();
        got_time.delete();
        for (int i = 0; i < 100; i++) begin
            bus.wr_en_i   = (i < 16);
            bus.wr_data_i = 8'(8'h30 + i);
            tick();
            if (bus.full_o === 1'b1) full_seen = 1'b1;
            if (bus.tx_irq_o === 1'b1) begin
                got_data.push_back(bus.tx_data_o);
                got_time.push_back(cyc);
            end
        end
        bus.wr_en_i = 1'b0;
        tests_run++;
        if (got_data.size() != 16) begin
            tests_failed++;
            $display("FAIL burst_count: got %0d pulses, want 16", got_data.size());
        end
        tests_run++;
        if (full_seen) begin
            tests_failed++;
            $display("FAIL burst_full: full_o=1 seen, want 0 (pops drain during burst)");
        end
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            tests_run++;
            if (got_data[i] !== 8'(8'h30 + i)) begin
                tests_failed++;
                $display("FAIL burst_data[%0d]: got %h want %h", i, got_data[i], 8'(8'h30 + i));
            end
            if (i > 0) begin
                tests_run++;
                if (got_time[i] - got_time[i-1] != 4) begin
                    tests_failed++;
                    $display("FAIL burst_spacing[%0d]: got %0d want 4", i, got_time[i] - got_time[i-1]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        bus.tx_busy_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_data_i = 8'(8'hA0 + i);
            tick();
        end
        tests_run++;
        if (bus.level_o !== 5'd16 || bus.full_o !== 1'b1 || bus.ovf_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_full: level=%0d full=%b ovf=%b, want 16 1 1",
                     bus.level_o, bus.full_o, bus.ovf_o);
        end
        bus.wr_data_i = 8'hEE;
        bus.clr_ovf_i = 1'b1;
        tick();
        tests_run++;
        if (bus.ovf_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set_wins: ovf=%b, want 1", bus.ovf_o);
        end
        bus.wr_en_i = 1'b0;
        tick();
        bus.clr_ovf_i = 1'b0;
        tests_run++;
        if (bus.ovf_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: ovf=%b, want 0", bus.ovf_o);
        end
        bus.tx_busy_i = 1'b0;
        collect(90);
        tests_run++;
        if (got_data.size() != 16) begin
            tests_failed++;
            $display("FAIL ovf_drain_count: got %0d pulses, want 16", got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            tests_run++;
            if (got_data[i] !== 8'(8'hA0 + i)) begin
                tests_failed++;
                $display("FAIL ovf_drain_data[%0d]: got %h want %h", i, got_data[i], 8'(8'hA0 + i));
            end
        end
    endtask

    task automatic test_busy_handshake();
        int  busy_rem   = 0;
        bit  start_next = 1'b0;
        bit  violation  = 1'b0;
        bus.tx_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_data_i = 8'(8'hC0 + i);
            tick();
        end
        bus.wr_en_i   = 1'b0;
        bus.tx_busy_i = 1'b0;
        got_data.delete();
        got_time.delete();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.tx_irq_o === 1'b1) begin
                if (bus.tx_busy_i) violation = 1'b1;
                got_data.push_back(bus.tx_data_o);
                got_time.push_back(cyc);
            end
            if (busy_rem > 0) begin
                busy_rem--;
                if (busy_rem == 0) bus.tx_busy_i = 1'b0;
            end
            if (start_next) begin
                bus.tx_busy_i = 1'b1;
                busy_rem      = 87;
                start_next    = 1'b0;
            end
            if (bus.tx_irq_o === 1'b1) start_next = 1'b1;
        end
        bus.tx_busy_i = 1'b0;
        tests_run++;
        if (violation) begin
            tests_failed++;
            $display("FAIL busy_launch: tx_irq_o=1 after an edge with tx_busy_i=1, want never");
        end
        tests_run++;
        if (got_data.size() != 3) begin
            tests_failed++;
            $display("FAIL busy_count: got %0d pulses, want 3", got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 3; i++) begin
            tests_run++;
            if (got_data[i] !== 8'(8'hC0 + i)) begin
                tests_failed++;
                $display("FAIL busy_data[%0d]: got %h want %h", i, got_data[i], 8'(8'hC0 + i));
            end
            if (i > 0) begin
                tests_run++;
                if (got_time[i] - got_time[i-1] != 89) begin
                    tests_failed++;
                    $display("FAIL busy_spacing[%0d]: got %0d want 89", i, got_time[i] - got_time[i-1]);
                end
            end
        end
    endtask

    task automatic test_full_pop();
        bus.tx_busy_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_data_i = 8'(8'h60 + i);
            tick();
        end
        tests_run++;
        if (bus.full_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL fp_full: full=%b, want 1", bus.full_o);
        end
        bus.tx_busy_i = 1'b0;
        bus.wr_data_i = 8'h55;
        tick();
        bus.wr_en_i = 1'b0;
        tests_run++;
        if (bus.tx_irq_o !== 1'b1 || bus.tx_data_o !== 8'h60 || bus.level_o !== 5'd16 || bus.ovf_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL fp_launch_write: irq=%b data=%h level=%0d ovf=%b, want 1 60 16 0",
                     bus.tx_irq_o, bus.tx_data_o, bus.level_o, bus.ovf_o);
        end
        collect(80);
        tests_run++;
        if (got_data.size() != 16) begin
            tests_failed++;
            $display("FAIL fp_count: got %0d pulses, want 16", got_data.size());
        end else begin
            tests_run++;
            if (got_data[14] !== 8'h6F || got_data[15] !== 8'h55) begin
                tests_failed++;
                $display("FAIL fp_order: last two %h %h, want 6f 55", got_data[14], got_data[15]);
            end
        end
    endtask

    task automatic test_flush_wrap();
        bus.tx_busy_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_data_i = 8'(8'h10 + i);
            tick();
        end
        bus.wr_en_i   = 1'b0;
        bus.tx_busy_i = 1'b0;
        collect(50);
        tests_run++;
        if (got_data.size() != 10) begin
            tests_failed++;
            $display("FAIL wrap_drain_count: got %0d pulses, want 10", got_data.size());
        end
        bus.tx_busy_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_data_i = 8'(8'h20 + i);
            tick();
        end
        bus.wr_en_i = 1'b0;
        tests_run++;
        if (bus.level_o !== 5'd10) begin
            tests_failed++;
            $display("FAIL wrap_level: level=%0d, want 10", bus.level_o);
        end
        bus.tx_busy_i = 1'b0;
        tick();
        tests_run++;
        if (bus.tx_irq_o !== 1'b1 || bus.tx_data_o !== 8'h20) begin
            tests_failed++;
            $display("FAIL wrap_launch: irq=%b data=%h, want 1 20", bus.tx_irq_o, bus.tx_data_o);
        end
        bus.flush_i   = 1'b1;
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = 8'h77;
        tick();
        bus.flush_i = 1'b0;
        bus.wr_en_i = 1'b0;
        tests_run++;
        if (bus.level_o !== 5'd0 || bus.empty_o !== 1'b1 || bus.ovf_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush: level=%0d empty=%b ovf=%b, want 0 1 0",
                     bus.level_o, bus.empty_o, bus.ovf_o);
        end
        collect(20);
        tests_run++;
        if (got_data.size() != 0) begin
            tests_failed++;
            $display("FAIL flush_quiet: got %0d pulses after flush, want 0", got_data.size());
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = 8'h00;
        bus.flush_i   = 1'b0;
        bus.clr_ovf_i = 1'b0;
        bus.tx_busy_i = 1'b0;
        test_reset();
        test_burst();
        test_overflow();
        test_busy_handshake();
        test_full_pop();
        test_flush_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
